// File: rtl/bath_clk_pkg.sv
// Shared types and constants for the bath heater timing chain.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: divider FSM state enum, standard half-period codes, and a
// helper that turns a half-period code into the resulting divide ratio.
package bath_clk_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Standard half-period codes for the heater's usual rates.
    localparam int unsigned HALF_FAST    = 0;     // divide-by-2
    localparam int unsigned HALF_DISPLAY = 499;   // display refresh base
    localparam int unsigned HALF_PWM     = 4999;  // heater PWM base

    // Divide ratio N = 2*(half+1) for a given half-period code.
    function automatic logic [31:0] div_ratio(input logic [31:0] half);
        return (half + 32'd1) << 1;
    endfunction

endpackage

// File: rtl/div_half_cnt.sv
// Half-period counter: counts 0..limit, wraps to 0 after limit, flags limit.
// Latency: tc is combinational from the registered count.
// Backpressure: none; clr overrides en.
// Ports: clk_in/rst (sync, active-high), clr (force count to 0), en (advance),
//        limit (terminal value), tc (count == limit).
module div_half_cnt
    import bath_clk_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc = (cnt_q == limit);

    // Wrapping at limit keeps cnt <= limit, so the increment never overflows.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable 50%-duty clock divider with glitch-free ratio changes.
// Latency: clk_out first rises cur_half+2 cycles after run is sampled high.
// Backpressure: cfg_ready drops while a code waits for the next period boundary.
// Ports: clk_in, rst (sync, active-high), run (level), cfg_valid/cfg_ready/
//        cfg_half (code handshake), clk_out (divided output), busy (not STOP),
//        tick (rise strobe, only when CLK_DIV_CTRL_TICK_EN is defined).
module clk_div_ctrl
    import bath_clk_pkg::*;
#(
    parameter int          WIDTH    = 16,
    parameter int unsigned DEF_HALF = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             busy
`ifdef CLK_DIV_CTRL_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [WIDTH-1:0] RST_HALF = DEF_HALF[WIDTH-1:0];

    state_e           state_q, state_d;
    logic             clk_out_q, clk_out_d;
    logic [WIDTH-1:0] cur_half_q, cur_half_d;
    logic [WIDTH-1:0] pend_half_q, pend_half_d;
    logic             pend_q, pend_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             busy_q, busy_d;
`ifdef CLK_DIV_CTRL_TICK_EN
    logic             tick_q, tick_d;
`endif

    logic tc;
    logic xfer;
    logic boundary;
    logic stop_entry;
    logic cnt_clr;
    logic cnt_en;

    // Counter holds 0 whenever the next state is STOP, runs otherwise.
    assign cnt_clr = (state_d == ST_STOP);
    assign cnt_en  = (state_q != ST_STOP);

    div_half_cnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk_in(clk_in),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cur_half_q),
        .tc    (tc)
    );

    always_comb begin
        state_d     = state_q;
        clk_out_d   = clk_out_q;
        cur_half_d  = cur_half_q;
        pend_half_d = pend_half_q;
        pend_d      = pend_q;

        xfer     = cfg_valid && cfg_ready_q;
        // Period boundary: the high-to-low toggle.
        boundary = (state_q != ST_STOP) && tc && clk_out_q;

        unique case (state_q)
            ST_STOP: begin
                clk_out_d = 1'b0;
                if (run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tc) begin
                    clk_out_d = ~clk_out_q;
                end
                if (!run) begin
                    if (!clk_out_q) begin
                        // Cutting a low phase short cannot create a runt high.
                        state_d   = ST_STOP;
                        clk_out_d = 1'b0;
                    end else if (tc) begin
                        // High phase ends this cycle anyway: stop at the boundary.
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (tc) begin
                    clk_out_d = 1'b0;
                    state_d   = ST_STOP;
                end
            end
            default: begin
                state_d   = ST_STOP;
                clk_out_d = 1'b0;
            end
        endcase

        stop_entry = (state_q != ST_STOP) && (state_d == ST_STOP);

        // Pending code lands at a boundary or whenever we fall back to STOP.
        if (pend_q && (boundary || stop_entry)) begin
            cur_half_d = pend_half_q;
            pend_d     = 1'b0;
        end

        // A code taken on a boundary cycle waits for the following boundary;
        // with the divider idle (or going idle) it is safe to apply at once.
        if (xfer) begin
            pend_half_d = cfg_half;
            if ((state_q == ST_STOP) || stop_entry) begin
                cur_half_d = cfg_half;
            end else begin
                pend_d = 1'b1;
            end
        end

        cfg_ready_d = !pend_d;
        busy_d      = (state_d != ST_STOP);
`ifdef CLK_DIV_CTRL_TICK_EN
        tick_d      = clk_out_d && !clk_out_q;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= ST_STOP;
            clk_out_q   <= 1'b0;
            cur_half_q  <= RST_HALF;
            pend_half_q <= '0;
            pend_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef CLK_DIV_CTRL_TICK_EN
            tick_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clk_out_q   <= clk_out_d;
            cur_half_q  <= cur_half_d;
            pend_half_q <= pend_half_d;
            pend_q      <= pend_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
`ifdef CLK_DIV_CTRL_TICK_EN
            tick_q      <= tick_d;
`endif
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign clk_out   = clk_out_q;
    assign busy      = busy_q;
`ifdef CLK_DIV_CTRL_TICK_EN
    assign tick      = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: expected per-cycle outputs are queued
// as stimulus is applied and compared as the DUT advances.
// Latency/backpressure: n/a (testbench).
module tb_clk_div_ctrl;

    localparam int W = 16;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         run;
    logic         cfg_valid;
    logic [W-1:0] cfg_half;
    logic         cfg_ready;
    logic         clk_out;
    logic         busy;
`ifdef CLK_DIV_CTRL_TICK_EN
    logic         tick;
`endif

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(
        .WIDTH   (W),
        .DEF_HALF(1)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .run      (run),
        .cfg_valid(cfg_valid),
        .cfg_half (cfg_half),
        .cfg_ready(cfg_ready),
        .clk_out  (clk_out),
        .busy     (busy)
`ifdef CLK_DIV_CTRL_TICK_EN
        ,
        .tick     (tick)
`endif
    );

    typedef struct {
        string tag;
        logic  c;   // clk_out
        logic  b;   // busy
        logic  r;   // cfg_ready
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   slot        = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int n, input logic c, input logic b, input logic r);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.tag = tag;
            e.c   = c;
            e.b   = b;
            e.r   = r;
            sb.push_back(e);
        end
    endtask

    // Advance one clock and compare the oldest queued expectation.
    task automatic cyc();
        @(posedge clk_in);
        @(negedge clk_in);
        slot++;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("%s@%0d clk_out", e.tag, slot), clk_out, e.c);
            chk($sformatf("%s@%0d busy", e.tag, slot), busy, e.b);
            chk($sformatf("%s@%0d cfg_ready", e.tag, slot), cfg_ready, e.r);
        end
    endtask

    task automatic drain();
        while (sb.size() > 0) cyc();
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = '0;
        push("reset", 1, 0, 0, 1);
        drain();
        rst = 1'b0;

        // Default half=1: first rise 3 cycles after run, then 2 low / 2 high.
        run = 1'b1;
        for (int p = 0; p < 2; p++) begin
            push("def_lo", 2, 0, 1, 1);
            push("def_hi", 2, 1, 1, 1);
        end
        push("def_lo", 2, 0, 1, 1);
        drain();

        // Stop from the low phase (coincides with a rising toggle).
        run = 1'b0;
        push("stop_lo", 1, 0, 0, 1);
        drain();

        // Code taken in STOP; ready stays high.
        cfg_valid = 1'b1;
        cfg_half  = 16'd4;
        push("cfg_stop", 1, 0, 0, 1);
        drain();
        cfg_valid = 1'b0;

        // half=4: 5 low / 5 high.
        run = 1'b1;
        push("h4_lo", 5, 0, 1, 1);
        push("h4_hi", 5, 1, 1, 1);
        push("h4_lo", 5, 0, 1, 1);
        push("h4_hi", 3, 1, 1, 1);
        drain();
        // Drop run mid-high: remaining 2 high cycles, then fall with busy.
        run = 1'b0;
        push("h4_drain", 2, 1, 1, 1);
        push("h4_stop", 1, 0, 0, 1);
        drain();

        cfg_valid = 1'b1;
        cfg_half  = 16'd1;
        push("cfg_h1", 1, 0, 0, 1);
        drain();
        cfg_valid = 1'b0;

        // Ratio change 1 -> 3 offered during the high phase.
        run = 1'b1;
        push("chg_lo", 2, 0, 1, 1);
        push("chg_hi", 1, 1, 1, 1);
        drain();
        cfg_valid = 1'b1;
        cfg_half  = 16'd3;
        push("chg_pend", 1, 1, 1, 0);
        drain();
        cfg_half = 16'd7;   // offered while not ready: must be ignored
        push("chg_new_lo", 1, 0, 1, 1);
        drain();
        cfg_valid = 1'b0;
        push("chg_new_lo", 3, 0, 1, 1);
        push("chg_new_hi", 4, 1, 1, 1);
        push("chg_new_lo", 4, 0, 1, 1);
        drain();

        run = 1'b0;
        push("stop2", 1, 0, 0, 1);
        drain();
        cfg_valid = 1'b1;
        cfg_half  = 16'd2;
        push("cfg_h2", 1, 0, 0, 1);
        drain();
        cfg_valid = 1'b0;

        // half=2, run dropped one cycle into high: high lasts 3 total.
        run = 1'b1;
        push("h2_lo", 3, 0, 1, 1);
        push("h2_hi", 1, 1, 1, 1);
        drain();
        run = 1'b0;
        push("h2_drain", 2, 1, 1, 1);
        push("h2_stop", 4, 0, 0, 1);
        drain();

        // Pending code discarded by reset.
        run = 1'b1;
        push("rp_lo", 1, 0, 1, 1);
        drain();
        cfg_valid = 1'b1;
        cfg_half  = 16'd9;
        push("rp_pend", 1, 0, 1, 0);
        drain();
        cfg_valid = 1'b0;
        rst       = 1'b1;
        push("rp_reset", 1, 0, 0, 1);
        drain();
        rst = 1'b0;
        push("rp_def_lo", 2, 0, 1, 1);
        push("rp_def_hi", 2, 1, 1, 1);
        push("rp_def_lo", 2, 0, 1, 1);
        drain();
        run = 1'b0;
        push("rp_stop", 1, 0, 0, 1);
        drain();

`ifdef CLK_DIV_CTRL_TICK_EN
        begin
            int   ticks;
            logic prev;
            ticks     = 0;
            cfg_valid = 1'b1;
            cfg_half  = 16'd0;
            push("cfg_h0", 1, 0, 0, 1);
            drain();
            cfg_valid = 1'b0;
            prev = clk_out;
            run  = 1'b1;
            for (int i = 0; i < 100; i++) begin
                cyc();
                chk($sformatf("tick_align@%0d", i), tick, clk_out && !prev);
                if (tick) ticks++;
                prev = clk_out;
            end
            chk("tick_count", ticks, 50);
            run = 1'b0;
            cyc();
            cyc();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
